// File: rtl/enter_debouncer_pkg.sv
// Shared definitions for the ENTER push-button debouncer.
//   state_t : debouncer FSM state encoding
package enter_debouncer_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// Generic N-stage synchroniser for asynchronous board inputs.
// Ports:
//   clock : sampling clock
//   reset : asynchronous, active-high; loads RESET_VALUE into every stage
//   d     : asynchronous input level
//   q     : synchronised level (last stage)
module sync_chain #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VALUE}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/enter_debouncer.sv
// Debounces the raw ENTER push-button and emits one single-cycle pulse per
// accepted press for the ALU step controller.
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-high
//   button_in    : raw asynchronous button level
//   enter        : one-clock pulse per accepted press
//   button_level : debounced pressed level (1 = pressed)
//   busy         : high whenever the FSM is not idle
module enter_debouncer
    import enter_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic enter,
    output logic button_level,
    output logic busy
);

    // One spare bit so the counter can never wrap before reaching LAST.
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic   raw_s;
    logic   pressed_s;
    state_t state;
    logic [CW-1:0] count;

    // Synchroniser idles at the released level so reset never looks like a press.
    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (logic'(BUTTON_ACTIVE_LOW))
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (button_in),
        .q     (raw_s)
    );

    assign pressed_s = raw_s ^ BUTTON_ACTIVE_LOW;
    assign busy      = (state != StIdle);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            count        <= '0;
            enter        <= 1'b0;
            button_level <= 1'b0;
        end else begin
            enter <= 1'b0;
            case (state)
                StIdle: begin
                    if (pressed_s) begin
                        state <= StPressWait;
                        count <= ONE;
                    end else begin
                        count <= '0;
                    end
                end
                StPressWait: begin
                    if (!pressed_s) begin
                        state <= StIdle;
                        count <= '0;
                    end else if (count == LAST) begin
                        state        <= StHeld;
                        count        <= '0;
                        enter        <= 1'b1;
                        button_level <= 1'b1;
                    end else begin
                        count <= count + ONE;
                    end
                end
                StHeld: begin
                    if (!pressed_s) begin
                        state <= StReleaseWait;
                        count <= ONE;
                    end else begin
                        count <= '0;
                    end
                end
                StReleaseWait: begin
                    // A re-press here is release bounce: back to held, no pulse.
                    if (pressed_s) begin
                        state <= StHeld;
                        count <= '0;
                    end else if (count == LAST) begin
                        state        <= StIdle;
                        count        <= '0;
                        button_level <= 1'b0;
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    state        <= StIdle;
                    count        <= '0;
                    button_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enter_debouncer.sv
module tb_enter_debouncer;

    logic clock;
    logic reset;
    logic button_in;
    logic enter;
    logic button_level;
    logic busy;

    int checks   = 0;
    int failures = 0;

    enter_debouncer #(
        .DEBOUNCE_CYCLES   (4),
        .SYNC_STAGES       (2),
        .BUTTON_ACTIVE_LOW (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_in    (button_in),
        .enter        (enter),
        .button_level (button_level),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the ALU step controller: advances one state per enter pulse.
    // 0=OPCODE 1=OP_A 2=OP_B 3=OUT
    logic [1:0] ctrl;
    always @(posedge clock or posedge reset) begin
        if (reset) ctrl <= 2'd0;
        else if (enter) ctrl <= ctrl + 2'd1;
    end

    typedef struct {
        logic btn;
        logic exp_enter;
        logic exp_level;
        logic exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic b, input logic e, input logic l, input logic bz, input int n);
        vec_t v;
        v.btn = b; v.exp_enter = e; v.exp_level = l; v.exp_busy = bz;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input logic b);
        button_in = b;
        @(posedge clock);
        #1;
    endtask

    int pulses;
    int first_pulse;
    int consec;
    logic prev_enter;

    // Runs n cycles with a fixed button level, tallying pulses and back-to-back highs.
    task automatic run(input logic b, input int n);
        for (int k = 0; k < n; k++) begin
            tick(b);
            if (enter) begin
                pulses++;
                if (first_pulse < 0) first_pulse = k + 1;
                if (prev_enter) consec++;
            end
            prev_enter = enter;
        end
    endtask

    task automatic clear_stats();
        pulses = 0; first_pulse = -1; consec = 0; prev_enter = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        button_in = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {enter, button_level, busy}, 3'b000);
        reset = 1'b0;

        // Vector index i is applied before edge i+1 (edge 1 = first pressed sample).
        add(0, 0, 0, 0, 2);   // edges 1-2: synchroniser filling
        add(0, 0, 0, 1, 3);   // edges 3-5: PRESS_WAIT
        add(0, 1, 1, 1, 1);   // edge 6: pulse, HELD
        add(0, 0, 1, 1, 2);   // edges 7-8
        add(1, 0, 1, 1, 5);   // edges 9-13: release qualifying
        add(1, 0, 0, 0, 1);   // edge 14: IDLE
        add(0, 0, 0, 0, 2);   // edges 15-16: press bounce begins
        add(1, 0, 0, 1, 1);   // edge 17
        add(0, 0, 0, 1, 1);   // edge 18
        add(0, 0, 0, 0, 1);   // edge 19: bounce seen, back to IDLE
        add(0, 0, 0, 1, 3);   // edges 20-22
        add(0, 1, 1, 1, 1);   // edge 23: single pulse
        add(0, 0, 1, 1, 1);   // edge 24
        add(1, 0, 1, 1, 1);   // edge 25: release bounce 1,0,1
        add(0, 0, 1, 1, 1);   // edge 26
        add(1, 0, 1, 1, 5);   // edges 27-31
        add(1, 0, 0, 0, 3);   // edges 32-34: released

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].btn);
            check($sformatf("vec%0d_enter_level_busy", i),
                  {enter, button_level, busy},
                  {vecs[i].exp_enter, vecs[i].exp_level, vecs[i].exp_busy});
        end

        // Long hold then a clean re-press: exactly two 1-cycle pulses.
        clear_stats();
        run(0, 1000);
        check("long_hold_level", button_level, 1);
        run(1, 20);
        run(0, 20);
        run(1, 20);
        check("long_hold_pulses", pulses, 2);
        check("long_hold_width", consec, 0);

        // Reset mid-PRESS_WAIT with the button still pressed.
        clear_stats();
        run(0, 3);
        reset = 1'b1;
        #1;
        check("rst_pw_async_clear", {enter, button_level, busy}, 3'b000);
        @(posedge clock);
        #1;
        check("rst_pw_no_pulse", pulses + int'(enter), 0);
        reset = 1'b0;
        clear_stats();
        run(0, 12);
        check("rst_pw_pulses", pulses, 1);
        check("rst_pw_latency", first_pulse, 6);

        // Reset mid-HELD: level drops at once, no pulse after release.
        reset = 1'b1;
        #1;
        check("rst_held_level", button_level, 0);
        button_in = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_stats();
        run(1, 12);
        check("rst_held_no_pulse", pulses, 0);

        // Controller stand-in steps OPCODE->OP_A->OP_B->OUT->OPCODE.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            clear_stats();
            run(0, 10);
            run(1, 10);
            check($sformatf("ctrl_press%0d_pulses", p), pulses, 1);
            check($sformatf("ctrl_press%0d_state", p), ctrl, (p + 1) % 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
